// File: rtl/axis_bram_writer.sv
// axis_bram_writer: accepts one AXI4-Stream packet of len beats and writes it into
// consecutive BRAM words from BASE_ADDR, flagging packets whose tlast disagrees with len.
module axis_bram_writer #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 32768
) (
    input  logic              aclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       len,
    output logic              busy,
    output logic              done,
    output logic              err_early_last,
    output logic              err_no_last,
    output logic [15:0]       word_count,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din
);

    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_busy;
    logic              r_done;
    logic              r_err_early;
    logic              r_err_no_last;
    logic              r_bram_en;
    logic [15:0]       r_len;
    logic [15:0]       r_count;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic              w_tready;
    logic              w_start_ok;
    logic              w_run_beat;
    logic              w_final;
    logic              w_flush_entry;
    logic [15:0]       w_count_inc;

    assign w_count_inc   = r_count + 16'd1;
    assign w_final       = (w_count_inc == r_len);
    assign w_flush_entry = (w_next == S_FLUSH);

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_tready   = 1'b0;
        w_start_ok = 1'b0;
        w_run_beat = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_ok = 1'b1;
                    if (len != 16'd0) begin
                        w_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_tready = 1'b1;
                if (s_axis_tvalid) begin
                    w_run_beat = 1'b1;
                    if (s_axis_tlast) begin
                        w_next = S_FLUSH;
                    end else if (w_final) begin
                        w_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Surplus beats are swallowed so the upstream packet can finish
                w_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err_early   <= 1'b0;
            r_err_no_last <= 1'b0;
            r_bram_en     <= 1'b0;
            r_len         <= '0;
            r_count       <= '0;
            r_idx         <= '0;
            r_addr        <= '0;
            r_din         <= '0;
        end else begin
            r_done    <= 1'b0;
            r_bram_en <= 1'b0;
            if (w_start_ok) begin
                r_err_early   <= 1'b0;
                r_err_no_last <= 1'b0;
                r_count       <= '0;
                r_idx         <= '0;
                r_len         <= len;
                r_busy        <= (len != 16'd0);
                r_done        <= (len == 16'd0);
            end
            if (w_run_beat) begin
                r_bram_en <= 1'b1;
                r_addr    <= BASE + r_idx;
                r_din     <= s_axis_tdata;
                r_idx     <= r_idx + ADDR_W'(1);
                r_count   <= w_count_inc;
                if (s_axis_tlast && !w_final) begin
                    r_err_early <= 1'b1;
                end
                if (w_final && !s_axis_tlast) begin
                    r_err_no_last <= 1'b1;
                end
            end
            // done and the final write land together in FLUSH, with busy already low
            if (w_flush_entry) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign s_axis_tready  = w_tready;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err_early_last = r_err_early;
    assign err_no_last    = r_err_no_last;
    assign word_count     = r_count;
    assign bram_en        = r_bram_en;
    assign bram_we        = r_bram_en;
    assign bram_addr      = r_addr;
    assign bram_din       = r_din;

endmodule

// File: tb/tb_axis_bram_writer.sv
// Directed bench for axis_bram_writer: a default instance plus one based near the top
// of the address space, both fed by the same stream and control inputs.
module tb_axis_bram_writer;

    logic        aclk;
    logic        rst_n;
    logic        start;
    logic [15:0] len;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;

    logic        busy, done, errEarly, errNoLast, tready, bramEn, bramWe;
    logic [15:0] wordCount, bramAddr;
    logic [31:0] bramDin;

    logic        busy2, done2, errEarly2, errNoLast2, tready2, bramEn2, bramWe2;
    logic [15:0] wordCount2, bramAddr2;
    logic [31:0] bramDin2;

    int          checks = 0;
    int          errors = 0;
    int          doneCount = 0;
    logic [47:0] wrQueue[$];
    logic [47:0] wrQueue2[$];

    axis_bram_writer #(.DATA_W(32), .ADDR_W(16), .BASE_ADDR(32768)) dut (
        .aclk(aclk), .rst_n(rst_n), .start(start), .len(len),
        .busy(busy), .done(done), .err_early_last(errEarly), .err_no_last(errNoLast),
        .word_count(wordCount), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready), .s_axis_tlast(tlast), .bram_en(bramEn), .bram_we(bramWe),
        .bram_addr(bramAddr), .bram_din(bramDin)
    );

    axis_bram_writer #(.DATA_W(32), .ADDR_W(16), .BASE_ADDR(65534)) dutWrap (
        .aclk(aclk), .rst_n(rst_n), .start(start), .len(len),
        .busy(busy2), .done(done2), .err_early_last(errEarly2), .err_no_last(errNoLast2),
        .word_count(wordCount2), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready2), .s_axis_tlast(tlast), .bram_en(bramEn2), .bram_we(bramWe2),
        .bram_addr(bramAddr2), .bram_din(bramDin2)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Capture every BRAM write and done pulse, sampled half a cycle after the edge
    always @(negedge aclk) begin
        if (bramEn) wrQueue.push_back({bramAddr, bramDin});
        if (bramEn2) wrQueue2.push_back({bramAddr2, bramDin2});
        if (done) doneCount++;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic doStart(input logic [15:0] l);
        start = 1'b1;
        len   = l;
        @(negedge aclk);
        start = 1'b0;
        len   = 16'd0;
    endtask

    task automatic sendBeat(input logic [31:0] d, input logic l);
        int n;
        n      = 0;
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        while (!tready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("[TB] FAIL beat_timeout data=%h tready=%b required=1", d, tready);
        end else begin
            @(negedge aclk);
        end
    endtask

    task automatic idleStream();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = 16'd0; idleStream(); tdata = '0;
        waitCycles(3);
        checks++;
        if ({busy, done, errEarly, errNoLast, wordCount, tready, bramEn, bramWe, bramAddr, bramDin} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs busy=%b done=%b wc=%0d en=%b addr=%h din=%h required all 0",
                     busy, done, wordCount, bramEn, bramAddr, bramDin);
        end
        rst_n = 1'b1;
        waitCycles(2);
        checks++;
        if ({busy, done, tready, bramEn} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle busy=%b done=%b tready=%b en=%b required 0", busy, done, tready, bramEn);
        end
    endtask

    task automatic test_single_packet();
        logic [47:0] exp;
        wrQueue.delete(); doneCount = 0;
        doStart(16'd4);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t1_busy got=%b exp=1", busy); end
        for (int i = 0; i < 3; i++) sendBeat(32'hA0 + i, 1'b0);
        sendBeat(32'hA3, 1'b1);
        checks++;
        if ({done, busy, bramWe, bramAddr, bramDin} !== {1'b1, 1'b0, 1'b1, 16'd32771, 32'hA3}) begin
            errors++;
            $display("[TB] FAIL t1_final_write done=%b busy=%b we=%b addr=%0d din=%h exp 1 0 1 32771 a3",
                     done, busy, bramWe, bramAddr, bramDin);
        end
        idleStream();
        @(negedge aclk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL t1_done_pulse got=%b exp=0", done); end
        waitCycles(1);
        for (int i = 0; i < 4; i++) begin
            exp = {16'(32768 + i), 32'(32'hA0 + i)};
            checks++;
            if (i >= wrQueue.size() || wrQueue[i] !== exp) begin
                errors++;
                $display("[TB] FAIL t1_write%0d got=%h exp=%h", i, (i < wrQueue.size()) ? wrQueue[i] : 48'hx, exp);
            end
        end
        checks++;
        if ({wrQueue.size(), doneCount, wordCount, errEarly, errNoLast} !== {32'd4, 32'd1, 16'd4, 2'b00}) begin
            errors++;
            $display("[TB] FAIL t1_summary writes=%0d dones=%0d wc=%0d errs=%b%b exp 4 1 4 00",
                     wrQueue.size(), doneCount, wordCount, errEarly, errNoLast);
        end
    endtask

    task automatic test_throttled();
        logic [47:0] exp;
        wrQueue.delete(); doneCount = 0;
        doStart(16'd8);
        for (int i = 0; i < 8; i++) begin
            sendBeat(32'hB0 + i, i == 7);
            if (i != 7) begin
                idleStream();
                @(negedge aclk);
                checks++;
                if (bramEn !== 1'b0) begin errors++; $display("[TB] FAIL t2_idle_write%0d en=%b exp=0", i, bramEn); end
            end
        end
        idleStream();
        waitCycles(2);
        for (int i = 0; i < 8; i++) begin
            exp = {16'(32768 + i), 32'(32'hB0 + i)};
            checks++;
            if (i >= wrQueue.size() || wrQueue[i] !== exp) begin
                errors++;
                $display("[TB] FAIL t2_write%0d got=%h exp=%h", i, (i < wrQueue.size()) ? wrQueue[i] : 48'hx, exp);
            end
        end
        checks++;
        if ({wrQueue.size(), doneCount, wordCount} !== {32'd8, 32'd1, 16'd8}) begin
            errors++;
            $display("[TB] FAIL t2_summary writes=%0d dones=%0d wc=%0d exp 8 1 8", wrQueue.size(), doneCount, wordCount);
        end
    endtask

    task automatic test_early_last();
        wrQueue.delete(); doneCount = 0;
        doStart(16'd6);
        sendBeat(32'hC0, 1'b0);
        sendBeat(32'hC1, 1'b0);
        sendBeat(32'hC2, 1'b1);
        checks++;
        if ({tready, done} !== 2'b01) begin errors++; $display("[TB] FAIL t3_flush tready=%b done=%b exp 0 1", tready, done); end
        tvalid = 1'b1; tlast = 1'b0; tdata = 32'hCC;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            checks++;
            if (tready !== 1'b0) begin errors++; $display("[TB] FAIL t3_tready_after%0d got=%b exp=0", i, tready); end
        end
        idleStream();
        waitCycles(1);
        checks++;
        if ({wrQueue.size(), doneCount, wordCount, errEarly, errNoLast} !== {32'd3, 32'd1, 16'd3, 2'b10}) begin
            errors++;
            $display("[TB] FAIL t3_summary writes=%0d dones=%0d wc=%0d early=%b nolast=%b exp 3 1 3 1 0",
                     wrQueue.size(), doneCount, wordCount, errEarly, errNoLast);
        end
        checks++;
        if (wrQueue.size() != 3 || wrQueue[2] !== {16'd32770, 32'hC2}) begin
            errors++;
            $display("[TB] FAIL t3_last_write got=%h exp=%h", (wrQueue.size() > 2) ? wrQueue[2] : 48'hx, {16'd32770, 32'hC2});
        end
    endtask

    task automatic test_no_last();
        logic [47:0] exp;
        wrQueue.delete(); doneCount = 0;
        doStart(16'd4);
        checks++;
        if (errEarly !== 1'b0) begin errors++; $display("[TB] FAIL t4_start_clears_early got=%b exp=0", errEarly); end
        for (int i = 0; i < 4; i++) sendBeat(32'hD0 + i, 1'b0);
        checks++;
        if ({errNoLast, done, busy} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL t4_len_reached nolast=%b done=%b busy=%b exp 1 0 1", errNoLast, done, busy);
        end
        sendBeat(32'hD4, 1'b0);
        sendBeat(32'hD5, 1'b0);
        sendBeat(32'hD6, 1'b1);
        checks++;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL t4_done_after_drain got=%b exp=1", done); end
        idleStream();
        waitCycles(2);
        for (int i = 0; i < 4; i++) begin
            exp = {16'(32768 + i), 32'(32'hD0 + i)};
            checks++;
            if (i >= wrQueue.size() || wrQueue[i] !== exp) begin
                errors++;
                $display("[TB] FAIL t4_write%0d got=%h exp=%h", i, (i < wrQueue.size()) ? wrQueue[i] : 48'hx, exp);
            end
        end
        checks++;
        if ({wrQueue.size(), doneCount, wordCount, errEarly, errNoLast} !== {32'd4, 32'd1, 16'd4, 2'b01}) begin
            errors++;
            $display("[TB] FAIL t4_summary writes=%0d dones=%0d wc=%0d early=%b nolast=%b exp 4 1 4 0 1",
                     wrQueue.size(), doneCount, wordCount, errEarly, errNoLast);
        end
    endtask

    task automatic test_zero_len();
        doneCount = 0;
        doStart(16'd0);
        checks++;
        if ({done, busy, errNoLast, tready, wordCount} !== {4'b1000, 16'd0}) begin
            errors++;
            $display("[TB] FAIL zero_len done=%b busy=%b nolast=%b tready=%b wc=%0d exp 1 0 0 0 0",
                     done, busy, errNoLast, tready, wordCount);
        end
        @(negedge aclk);
        checks++;
        if ({done, busy} !== 2'b00) begin errors++; $display("[TB] FAIL zero_len_after done=%b busy=%b exp 0 0", done, busy); end
    endtask

    task automatic test_addr_wrap();
        logic [15:0] expAddr[4];
        expAddr = '{16'd65534, 16'd65535, 16'd0, 16'd1};
        wrQueue2.delete();
        doStart(16'd4);
        for (int i = 0; i < 4; i++) sendBeat(32'hE0 + i, i == 3);
        idleStream();
        waitCycles(2);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= wrQueue2.size() || wrQueue2[i] !== {expAddr[i], 32'(32'hE0 + i)}) begin
                errors++;
                $display("[TB] FAIL t5_wrap%0d got=%h exp=%h", i, (i < wrQueue2.size()) ? wrQueue2[i] : 48'hx,
                         {expAddr[i], 32'(32'hE0 + i)});
            end
        end
        checks++;
        if ({wrQueue2.size(), errEarly2, errNoLast2, wordCount2} !== {32'd4, 2'b00, 16'd4}) begin
            errors++;
            $display("[TB] FAIL t5_summary writes=%0d errs=%b%b wc=%0d exp 4 00 4", wrQueue2.size(), errEarly2, errNoLast2, wordCount2);
        end
    endtask

    task automatic test_back_to_back();
        wrQueue.delete();
        doStart(16'd1);
        sendBeat(32'h50, 1'b1);
        checks++;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_done got=%b exp=1", done); end
        idleStream();
        start = 1'b1; len = 16'd2;
        @(negedge aclk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_start_in_flush busy=%b exp=0", busy); end
        @(negedge aclk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_start_after_done busy=%b exp=1", busy); end
        start = 1'b1; len = 16'd9;
        sendBeat(32'h51, 1'b0);
        start = 1'b0; len = 16'd0;
        sendBeat(32'h52, 1'b1);
        checks++;
        if ({done, errEarly, wordCount} !== {2'b10, 16'd2}) begin
            errors++;
            $display("[TB] FAIL b2b_second done=%b early=%b wc=%0d exp 1 0 2", done, errEarly, wordCount);
        end
        idleStream();
        waitCycles(2);
        checks++;
        if (wrQueue.size() != 3 || wrQueue[0] !== {16'd32768, 32'h50} || wrQueue[1] !== {16'd32768, 32'h51}
            || wrQueue[2] !== {16'd32769, 32'h52}) begin
            errors++;
            $display("[TB] FAIL b2b_writes count=%0d exp 3 entries 8000/50 8000/51 8001/52", wrQueue.size());
        end
    endtask

    task automatic test_reset_mid();
        doStart(16'd5);
        sendBeat(32'hF0, 1'b0);
        tdata = 32'hF1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, errEarly, errNoLast, wordCount, tready, bramEn, bramWe, bramAddr, bramDin} !== '0) begin
            errors++;
            $display("[TB] FAIL t6_async_reset busy=%b wc=%0d tready=%b en=%b addr=%h din=%h required all 0",
                     busy, wordCount, tready, bramEn, bramAddr, bramDin);
        end
        @(negedge aclk);
        rst_n = 1'b1;
        idleStream();
        @(negedge aclk);
        checks++;
        if ({busy, tready, bramEn} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL t6_idle_after_reset busy=%b tready=%b en=%b exp 0", busy, tready, bramEn);
        end
        wrQueue.delete(); doneCount = 0;
        doStart(16'd2);
        sendBeat(32'h60, 1'b0);
        sendBeat(32'h61, 1'b1);
        idleStream();
        waitCycles(2);
        checks++;
        if (wrQueue.size() != 2 || wrQueue[0] !== {16'd32768, 32'h60} || wrQueue[1] !== {16'd32769, 32'h61}
            || {doneCount, errEarly, errNoLast, wordCount} !== {32'd1, 2'b00, 16'd2}) begin
            errors++;
            $display("[TB] FAIL t6_recovery writes=%0d dones=%0d errs=%b%b wc=%0d exp 2 1 00 2",
                     wrQueue.size(), doneCount, errEarly, errNoLast, wordCount);
        end
        doStart(16'd0);
        checks++;
        if ({done, busy} !== 2'b10) begin errors++; $display("[TB] FAIL t6_zero_len done=%b busy=%b exp 1 0", done, busy); end
        waitCycles(2);
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_throttled();
        test_early_last();
        test_no_last();
        test_zero_len();
        test_addr_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
